// File: rtl/pipelined_addsub.sv
// pipelined_addsub: segmented-carry add/subtract with valid/ready on both sides.
// Each stage resolves SEG result bits; flags and saturation are formed in the output register.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    input  logic             signed_op,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int M    = WIDTH - 1;
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] v, v_s, c_q, c_s, c_n;
    logic [STAGES:0]   adv;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  x_q [STAGES];
    logic [WIDTH-1:0]  a_s [STAGES];
    logic [WIDTH-1:0]  b_s [STAGES];
    logic [WIDTH-1:0]  x_s [STAGES];
    logic [WIDTH-1:0]  x_n [STAGES];
    logic [SEG:0]      seg [STAGES];
    logic [2:0]        ctl_q [STAGES];
    logic [2:0]        ctl_s [STAGES];

    always_comb begin
        adv[STAGES] = !out_valid || out_ready;
        for (int i = LAST; i >= 0; i--) adv[i] = !v[i] || adv[i+1];
    end
    assign in_ready = adv[0];

    // b is pre-inverted for subtract, so a borrow chain is just an add chain
    always_comb begin
        v_s      = '0;
        c_s      = '0;
        c_n      = '0;
        a_s[0]   = a;
        b_s[0]   = sub ? ~b : b;
        x_s[0]   = '0;
        c_s[0]   = sub ^ carry_in;
        ctl_s[0] = {sub, signed_op, sat};
        v_s[0]   = in_valid;
        for (int i = 1; i < STAGES; i++) begin
            a_s[i]   = a_q[i-1];
            b_s[i]   = b_q[i-1];
            x_s[i]   = x_q[i-1];
            c_s[i]   = c_q[i-1];
            ctl_s[i] = ctl_q[i-1];
            v_s[i]   = v[i-1];
        end
        for (int i = 0; i < STAGES; i++) begin
            seg[i] = {1'b0, a_s[i][i*SEG +: SEG]} + {1'b0, b_s[i][i*SEG +: SEG]} + (SEG+1)'(c_s[i]);
            x_n[i] = x_s[i];
            x_n[i][i*SEG +: SEG] = seg[i][SEG-1:0];
            c_n[i] = seg[i][SEG];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v   <= '0;
            c_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                x_q[i]   <= '0;
                ctl_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (adv[i]) begin
                    v[i]     <= v_s[i];
                    a_q[i]   <= a_s[i];
                    b_q[i]   <= b_s[i];
                    x_q[i]   <= x_n[i];
                    c_q[i]   <= c_n[i];
                    ctl_q[i] <= ctl_s[i];
                end
            end
        end
    end

    logic             sub_l, so_l, sat_l, co_n, sov, ov_n;
    logic [WIDTH-1:0] a_l, b_l, x_l, smin, sat_v, s_n;

    // with b already inverted, add and subtract share one signed-overflow test
    always_comb begin
        {sub_l, so_l, sat_l} = ctl_q[LAST];
        a_l   = a_q[LAST];
        b_l   = b_q[LAST];
        x_l   = x_q[LAST];
        co_n  = sub_l ^ c_q[LAST];
        sov   = (a_l[M] == b_l[M]) && (x_l[M] != a_l[M]);
        ov_n  = so_l ? sov : co_n;
        smin  = WIDTH'(1) << M;
        sat_v = so_l ? (a_l[M] ? smin : ~smin) : (sub_l ? '0 : '1);
        s_n   = (sat_l && ov_n) ? sat_v : x_l;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else if (adv[STAGES]) begin
            out_valid <= v[LAST];
            if (v[LAST]) begin
                sum       <= s_n;
                carry_out <= co_n;
                overflow  <= ov_n;
                zero      <= s_n == '0;
                negative  <= s_n[M];
            end
        end
    end
endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined add/subtract unit replacing the single-cycle 32-bit registered adder in the ALU datapath. Splits the carry chain into STAGES equal segments, one register stage each, so WIDTH scales without lengthening the critical path. Supports add/subtract, signed/unsigned flags, optional saturation and borrow-in, with a valid/ready handshake on both sides so the ALU sequencer can stall it.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of STAGES.
- STAGES, 4: pipeline depth = number of carry-chain segments (1..WIDTH); SEG = WIDTH/STAGES bits per stage.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- a, b  in  WIDTH each  operands.
- carry_in  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: a+b+carry_in; 1: a-b-carry_in.
- signed_op  in  1  select signed overflow/saturation semantics.
- sat  in  1  clamp result on overflow.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- carry_out  out  1  add: carry out of MSB; sub: borrow out (1 = a < b+carry_in unsigned).
- overflow  out  1  signed_op ? signed overflow : carry_out.
- zero, negative  out  1 each  sum==0; sum[WIDTH-1].

## Operation
- Internal form: x = a + (sub ? ~b : b) + (sub ? ~carry_in : carry_in), WIDTH+1 bits; raw carry c = bit WIDTH.
- carry_out = sub ? ~c : c.
- Signed overflow: add: a[msb]==b[msb] && x[msb]!=a[msb]; sub: a[msb]!=b[msb] && x[msb]!=a[msb].
- Stage k (0..STAGES-1) computes bits [k*SEG +: SEG] with the carry registered from stage k-1 (stage 0 uses the modified carry_in); upper operand bits and lower result bits are carried forward in skew registers; op controls (sub, signed_op, sat, a[msb], b[msb]) travel with the beat.
- Flags, saturation and zero/negative computed combinationally from the last stage's registers into the output register set.
- Saturation (sat=1 and overflow=1): signed: a[msb]=0 -> 0111..1, a[msb]=1 -> 1000..0; unsigned add -> all ones; unsigned sub -> 0. zero/negative reflect the clamped sum. carry_out and overflow still report the unclamped event.
- sat=0: sum is x[WIDTH-1:0] modulo 2^WIDTH.

## Timing
- Reset: all valid bits 0, in_ready 1 after reset deasserts, out_valid 0, sum 0, carry_out 0, overflow 0, zero 0, negative 0. Reset mid-operation discards every in-flight beat; no partial result ever appears.
- Beat accepted when in_valid && in_ready; result delivered when out_valid && out_ready.
- Latency: accepted at edge N -> out_valid high after edge N+STAGES (STAGES=1: next cycle, matching the old adder).
- Throughput: one beat per cycle while out_ready=1.
- Per-stage valid; stage k advances iff it is empty or stage k+1 advances (output register advances iff empty or out_ready). Bubbles collapse; in_ready = stage 0 empty or advancing (combinational from out_ready through the chain).
- out_ready=0 with out_valid=1: sum/flags/out_valid held stable; pipeline fills to STAGES+1 beats then in_ready drops; no beat dropped or duplicated.
- in_valid, operands and controls sampled only on acceptance; in_valid=0 cycles insert bubbles.

## Test plan
- Reset/latency (WIDTH=32, STAGES=4): after rst, a=0x0000_0001, b=0x0000_0002, add -> exactly 4 cycles later out_valid=1, sum=0x0000_0003, carry_out=0, overflow=0, zero=0.
- Carry across every segment: a=0xFFFF_FFFF, b=0, carry_in=1, add -> sum=0x0000_0000, carry_out=1, zero=1; unsigned overflow=1; signed_op=1 -> overflow=0.
- Signed overflow + saturation: a=0x7FFF_FFFF, b=1, signed_op=1, sat=1 -> sum=0x7FFF_FFFF, overflow=1; same with sat=0 -> sum=0x8000_0000, negative=1.
- Subtract/borrow: a=3, b=5, sub=1 -> sum=0xFFFF_FFFE, carry_out=1; with sat=1, signed_op=0 -> sum=0, zero=1; a=5, b=3, carry_in=1 -> sum=1, carry_out=0.
- Backpressure: stream 10 back-to-back beats (a=i, b=i), out_ready low for cycles 3-9 -> in_ready falls after 5 beats held, all 10 results 2i delivered in order, none lost/repeated, outputs stable while stalled.
- Reset mid-stream: assert rst with 3 beats in flight -> out_valid=0 immediately, no stale result after release; sweep STAGES=1,2,8 and WIDTH=8/64 with random operands against a reference model.
